// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of it.
// Words are queued through a valid/ready port and sent as
// start + DATA_W data bits (LSB first) + optional parity + 1 or 2 stop bits.
// Frame format controls are latched when a word leaves the FIFO, so they
// can be changed freely while a frame is on the line.
module uart_tx_fifo #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 10416,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          parity_en,
   input  logic                          parity_odd,
   input  logic                          two_stop,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_W);

   localparam logic [AW:0]   FULL       = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // FIFO state
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;

   // Transmitter state
   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              par_q, par_d;
   logic              par_en_q, par_en_d;
   logic              two_stop_q, two_stop_d;
   logic              tx_q, tx_d;

   logic              push;
   logic              pop;
   logic              load;
   logic              bit_end;
   logic [DATA_W-1:0] head;

   assign in_ready   = ~rst & (count_q != FULL);
   assign push       = in_valid & in_ready;
   assign head       = mem_q[rd_ptr_q];
   assign bit_end    = (cnt_q == '0);
   assign tx         = tx_q;
   assign fifo_count = count_q;
   assign busy       = ~rst & ((state_q != IDLE) | (count_q != '0));

   // FIFO next state: write at the tail, read at the head, track occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage array holds no control state, so it is left out of reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Transmit FSM: bit timing, serialisation and frame-to-frame hand-off
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      sh_d       = sh_q;
      par_d      = par_q;
      par_en_d   = par_en_q;
      two_stop_d = two_stop_q;
      tx_d       = tx_q;
      load       = 1'b0;

      if (state_q != IDLE && !bit_end) begin
         cnt_d = cnt_q - CW'(1);
      end

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (count_q != '0) load = 1'b1;
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               tx_d    = sh_q[0];
               sh_d    = sh_q >> 1;
               bit_d   = '0;
               cnt_d   = CNT_RELOAD;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = CNT_RELOAD;
               if (bit_q == LAST_BIT) begin
                  bit_d = '0;
                  if (par_en_q) begin
                     state_d = PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  tx_d  = sh_q[0];
                  sh_d  = sh_q >> 1;
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               tx_d    = 1'b1;
               bit_d   = '0;
               cnt_d   = CNT_RELOAD;
            end
         end
         STOP: begin
            // bit_q counts stop bits already completed
            if (bit_end) begin
               if (two_stop_q && bit_q == '0) begin
                  bit_d = BW'(1);
                  cnt_d = CNT_RELOAD;
               end else if (count_q != '0) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // Start of a new frame: take the head word and snapshot the format
      if (load) begin
         sh_d       = head;
         par_d      = (^head) ^ parity_odd;
         par_en_d   = parity_en;
         two_stop_d = two_stop;
         cnt_d      = CNT_RELOAD;
         bit_d      = '0;
         state_d    = START;
         tx_d       = 1'b0;
      end
   end

   assign pop = load;

   // Transmitter registers; reset aborts any frame and idles the line high
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         sh_q       <= '0;
         par_q      <= 1'b0;
         par_en_q   <= 1'b0;
         two_stop_q <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         sh_q       <= sh_d;
         par_q      <= par_d;
         par_en_q   <= par_en_d;
         two_stop_q <= two_stop_d;
         tx_q       <= tx_d;
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 10416, meaning clk cycles per UART bit; legal minimum 2.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries; power of 2, minimum 2.
REQ-004 Port: clk  input  1  single clock; all logic on the rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: in_data  input  DATA_W  word to transmit.
REQ-007 Port: in_valid  input  1  in_data valid.
REQ-008 Port: in_ready  output  1  FIFO can accept; a word is accepted on an edge where in_valid and in_ready are both 1.
REQ-009 Port: parity_en  input  1  1 = append a parity bit.
REQ-010 Port: parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-011 Port: two_stop  input  1  1 = two stop bits, 0 = one.
REQ-012 Port: tx  output  1  serial line; idle high; registered.
REQ-013 Port: busy  output  1  high when a frame is in progress or the FIFO is non-empty.
REQ-014 Port: fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words queued (excludes the word being sent).

Function
REQ-015 The FIFO SHALL be first-in first-out, and in_ready SHALL equal (fifo_count != FIFO_DEPTH) outside reset.
REQ-016 While full, a push SHALL be refused even if a pop happens on the same edge; there is no bypass, and every word passes through the FIFO.
REQ-017 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave fifo_count unchanged.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop on that edge, load the shift register, latch parity_en, parity_odd and two_stop, enter START and drive tx=0.
REQ-020 Latency: a word accepted at edge E into an empty FIFO with the FSM in IDLE SHALL make tx go low at edge E+1.
REQ-021 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at each bit boundary.
REQ-022 START SHALL be followed by DATA.
REQ-023 DATA SHALL send DATA_W bits LSB first, then go to PARITY if the latched parity_en=1, else to STOP.
REQ-024 The parity bit SHALL equal the XOR of the data bits, inverted when the latched parity_odd=1.
REQ-025 STOP SHALL drive tx=1 for 1 bit period, or 2 when the latched two_stop=1.
REQ-026 At the end of STOP, the FSM SHALL pop and enter START on the same edge if the FIFO is non-empty (no idle cycle between frames); otherwise it SHALL enter IDLE.
REQ-027 Frame length SHALL be (1 + DATA_W + parity_en + 1 + two_stop) * CLKS_PER_BIT cycles.
REQ-028 Changes to parity_en, parity_odd or two_stop mid-frame SHALL NOT affect the frame in progress.
REQ-029 busy SHALL be combinational: (state != IDLE) OR (fifo_count != 0).

Reset
REQ-030 On any edge with rst=1, the block SHALL set state=IDLE, tx=1, fifo_count=0 and in_ready=0, clear the bit counter and pointers, and discard queued words.
REQ-031 Reset mid-frame SHALL abort the frame, with tx=1 from the edge rst is sampled.
REQ-032 in_ready SHALL be 1 on the first edge after rst deasserts.
REQ-033 busy SHALL be 0 while rst is held.

Verification (CLKS_PER_BIT=4, DATA_W=8, FIFO_DEPTH=4)
REQ-034 Push 0x55 with parity_en=0 and two_stop=0 -> tx reads 0,1,0,1,0,1,0,1,0,1, each bit for 4 cycles (40 cycles total), then 1; busy drops 40 cycles after tx falls.
REQ-035 Push 0x07 with parity_en=1 and parity_odd=0 -> parity bit 1; repeat with parity_odd=1 -> parity bit 0; frame is 44 cycles.
REQ-036 Push 0xA3 with two_stop=1 -> tx high for 8 cycles after the last data bit; a second queued word starts exactly at the following edge, with no extra idle cycle.
REQ-037 Push 6 words back-to-back -> word 1 is popped, words 2-5 fill the FIFO (fifo_count=4), in_ready=0 and word 6 is stalled; all 5 accepted words are transmitted in order.
REQ-038 Assert rst for 1 cycle during data bit 3 with 2 words queued -> tx=1, fifo_count=0, in_ready=1 on the next edge and no further frames.
REQ-039 Push into a FIFO with fifo_count=2 while the FSM pops at end of STOP -> fifo_count stays 2.
